// File: rtl/sel_mem_pkg.sv
// Shared encodings for the memory-select fabric: owner codes, arbiter
// state codes and the default read data returned on a timed-out access.
package sel_mem_pkg;

  // Owner encoding. Bit 0 is the CPU and bit 1 is the DMA, so a one-hot grant
  // vector casts directly to an owner code.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_t;

  // Arbiter FSM states.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Read data presented to a master whose transaction timed out.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way pick between the CPU (req[0]) and the DMA (req[1]).
// mode=0: round-robin, where a sole requester wins and a tie goes to the
//         requester that did not own the port last.
// mode=1: the CPU wins every tie; the DMA only wins when it is alone.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,   // 1 = DMA owned the port most recently
  input  logic       mode,
  output logic [1:0] grant
);

  // One-hot grant from the request pair, the previous owner and the mode.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (mode) begin
          grant = 2'b01;
        end else begin
          grant = last ? 2'b01 : 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram2_arbiter.sv
// Shares RAM port 2 between the CPU data interface and the DMA interface.
// A single transaction is in flight at a time. The winner's request is
// registered onto the ram2 side. The slave's ack is steered combinationally
// back to the owner only. A per-transaction timeout forces an error ack so a
// hung slave cannot deadlock a master.
//
// Handshake (both master sides and the ram2 side): a master raises stb with
// we/addr/data and holds all of them stable until it sees a one-cycle ack.
// On the following cycle it may drop stb or present a new request. The ack
// cycle is the only cycle in which data_o/err_o carry meaning. The ram2
// slave must pulse ack only while ram2_stb_o is high.
module ram2_arbiter
  import sel_mem_pkg::*;
#(
  parameter int                ADDR_W        = 16,
  parameter int                DATA_W        = 32,
  parameter int                PRIORITY_MODE = 0,
  parameter int                TIMEOUT       = 64,
  parameter logic [DATA_W-1:0] ERR_DATA      = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,

  input  logic              cpu_data_stb_i,
  input  logic              cpu_data_we_i,
  input  logic [ADDR_W-1:0] cpu_data_addr_i,
  input  logic [DATA_W-1:0] cpu_data_data_i,
  output logic              cpu_data_ack_o,
  output logic              cpu_data_err_o,
  output logic [DATA_W-1:0] cpu_data_data_o,

  input  logic              dma_stb_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_data_i,
  output logic              dma_ack_o,
  output logic              dma_err_o,
  output logic [DATA_W-1:0] dma_data_o,

  output logic              ram2_stb_o,
  output logic              ram2_we_o,
  output logic [ADDR_W-1:0] ram2_addr_o,
  output logic [DATA_W-1:0] ram2_data_o,
  input  logic              ram2_ack_i,
  input  logic [DATA_W-1:0] ram2_data_i,

  output logic [1:0]        arb_owner_o
);

  // A counter wide enough to hold TIMEOUT. It saturates at TIMEOUT, so it
  // never wraps back into a spurious match.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t       state_q;
  owner_t           owner_q;
  owner_t           last_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       req;
  logic [1:0]       grant;
  logic             busy;
  logic             timeout_hit;
  logic             done;
  logic [DATA_W-1:0] resp_data;

  assign req  = {dma_stb_i, cpu_data_stb_i};
  assign busy = (state_q == ARB_BUSY);

  // The count is 0 on the first BUSY cycle, so TIMEOUT-1 marks the
  // TIMEOUT-th BUSY cycle. A real ack in that same cycle takes precedence.
  assign timeout_hit = (TIMEOUT != 0) && busy && !ram2_ack_i &&
                       (int'(cnt_q) == TIMEOUT - 1);
  assign done        = busy && (ram2_ack_i || timeout_hit);
  assign resp_data   = ram2_ack_i ? ram2_data_i : ERR_DATA;

  arb_rr2 u_pick (
    .req   (req),
    .last  (last_q == OWN_DMA),
    .mode  (PRIORITY_MODE != 0),
    .grant (grant)
  );

  // Arbiter FSM: grant and capture in IDLE, hold and count in BUSY.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      last_q      <= OWN_DMA;
      cnt_q       <= '0;
      ram2_stb_o  <= 1'b0;
      ram2_we_o   <= 1'b0;
      ram2_addr_o <= '0;
      ram2_data_o <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            state_q    <= ARB_BUSY;
            owner_q    <= owner_t'(grant);
            cnt_q      <= '0;
            ram2_stb_o <= 1'b1;
            if (grant[0]) begin
              ram2_we_o   <= cpu_data_we_i;
              ram2_addr_o <= cpu_data_addr_i;
              ram2_data_o <= cpu_data_data_i;
            end else begin
              ram2_we_o   <= dma_we_i;
              ram2_addr_o <= dma_addr_i;
              ram2_data_o <= dma_data_i;
            end
          end
        end
        ARB_BUSY: begin
          if (done) begin
            state_q    <= ARB_IDLE;
            ram2_stb_o <= 1'b0;
            last_q     <= owner_q;
            owner_q    <= OWN_NONE;
          end else if (int'(cnt_q) < TIMEOUT) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          owner_q    <= OWN_NONE;
          ram2_stb_o <= 1'b0;
        end
      endcase
    end
  end

  // Steer the completion (real or forced) to the owner only; everyone else sees zeros.
  always_comb begin
    cpu_data_ack_o  = 1'b0;
    cpu_data_err_o  = 1'b0;
    cpu_data_data_o = '0;
    dma_ack_o       = 1'b0;
    dma_err_o       = 1'b0;
    dma_data_o      = '0;
    if (done) begin
      if (owner_q == OWN_CPU) begin
        cpu_data_ack_o  = 1'b1;
        cpu_data_err_o  = timeout_hit;
        cpu_data_data_o = resp_data;
      end else if (owner_q == OWN_DMA) begin
        dma_ack_o  = 1'b1;
        dma_err_o  = timeout_hit;
        dma_data_o = resp_data;
      end
    end
  end

  assign arb_owner_o = owner_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Bench for ram2_arbiter. Instance u_a runs round-robin with an 8-cycle
// timeout. Instance u_b runs CPU fixed priority with the timeout disabled.
module tb_ram2_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // instance A
  logic a_cpu_stb, a_cpu_we, a_cpu_ack, a_cpu_err;
  logic [AW-1:0] a_cpu_addr;
  logic [DW-1:0] a_cpu_wd, a_cpu_rd;
  logic a_dma_stb, a_dma_we, a_dma_ack, a_dma_err;
  logic [AW-1:0] a_dma_addr;
  logic [DW-1:0] a_dma_wd, a_dma_rd;
  logic a_r_stb, a_r_we, a_r_ack;
  logic [AW-1:0] a_r_addr;
  logic [DW-1:0] a_r_wd, a_r_rd;
  logic [1:0] a_owner;

  // instance B
  logic b_cpu_stb, b_cpu_we, b_cpu_ack, b_cpu_err;
  logic [AW-1:0] b_cpu_addr;
  logic [DW-1:0] b_cpu_wd, b_cpu_rd;
  logic b_dma_stb, b_dma_we, b_dma_ack, b_dma_err;
  logic [AW-1:0] b_dma_addr;
  logic [DW-1:0] b_dma_wd, b_dma_rd;
  logic b_r_stb, b_r_we, b_r_ack;
  logic [AW-1:0] b_r_addr;
  logic [DW-1:0] b_r_wd, b_r_rd;
  logic [1:0] b_owner;

  ram2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0), .TIMEOUT(TO)) u_a (
    .sys_clk(clk), .sys_rst(rst_n),
    .cpu_data_stb_i(a_cpu_stb), .cpu_data_we_i(a_cpu_we), .cpu_data_addr_i(a_cpu_addr),
    .cpu_data_data_i(a_cpu_wd), .cpu_data_ack_o(a_cpu_ack), .cpu_data_err_o(a_cpu_err),
    .cpu_data_data_o(a_cpu_rd),
    .dma_stb_i(a_dma_stb), .dma_we_i(a_dma_we), .dma_addr_i(a_dma_addr), .dma_data_i(a_dma_wd),
    .dma_ack_o(a_dma_ack), .dma_err_o(a_dma_err), .dma_data_o(a_dma_rd),
    .ram2_stb_o(a_r_stb), .ram2_we_o(a_r_we), .ram2_addr_o(a_r_addr), .ram2_data_o(a_r_wd),
    .ram2_ack_i(a_r_ack), .ram2_data_i(a_r_rd), .arb_owner_o(a_owner)
  );

  ram2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(1), .TIMEOUT(0)) u_b (
    .sys_clk(clk), .sys_rst(rst_n),
    .cpu_data_stb_i(b_cpu_stb), .cpu_data_we_i(b_cpu_we), .cpu_data_addr_i(b_cpu_addr),
    .cpu_data_data_i(b_cpu_wd), .cpu_data_ack_o(b_cpu_ack), .cpu_data_err_o(b_cpu_err),
    .cpu_data_data_o(b_cpu_rd),
    .dma_stb_i(b_dma_stb), .dma_we_i(b_dma_we), .dma_addr_i(b_dma_addr), .dma_data_i(b_dma_wd),
    .dma_ack_o(b_dma_ack), .dma_err_o(b_dma_err), .dma_data_o(b_dma_rd),
    .ram2_stb_o(b_r_stb), .ram2_we_o(b_r_we), .ram2_addr_o(b_r_addr), .ram2_data_o(b_r_wd),
    .ram2_ack_i(b_r_ack), .ram2_data_i(b_r_rd), .arb_owner_o(b_owner)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_all();
    a_cpu_stb = 0; a_cpu_we = 0; a_cpu_addr = '0; a_cpu_wd = '0;
    a_dma_stb = 0; a_dma_we = 0; a_dma_addr = '0; a_dma_wd = '0;
    a_r_ack = 0; a_r_rd = '0;
    b_cpu_stb = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wd = '0;
    b_dma_stb = 0; b_dma_we = 0; b_dma_addr = '0; b_dma_wd = '0;
    b_r_ack = 0; b_r_rd = '0;
  endtask

  task automatic apply_reset();
    idle_all();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_all();
    rst_n = 0;
    step();
    #1;
    total++; if (a_r_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%0h exp=0", a_r_stb); end
    total++; if (a_owner !== 2'b00) begin bad++; $display("FAIL reset_owner got=%0h exp=0", a_owner); end
    total++; if (a_r_we !== 1'b0 || a_r_addr !== '0 || a_r_wd !== '0) begin
      bad++; $display("FAIL reset_regs got we=%0h addr=%0h data=%0h exp=0", a_r_we, a_r_addr, a_r_wd);
    end
    a_r_ack = 1;
    #1;
    total++; if (a_cpu_ack !== 1'b0 || a_dma_ack !== 1'b0) begin
      bad++; $display("FAIL reset_acks got cpu=%0h dma=%0h exp=0", a_cpu_ack, a_dma_ack);
    end
    total++; if (b_r_stb !== 1'b0 || b_owner !== 2'b00) begin
      bad++; $display("FAIL reset_b got stb=%0h owner=%0h exp=0", b_r_stb, b_owner);
    end
    a_r_ack = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_cpu_write();
    step();
    a_cpu_stb = 1; a_cpu_we = 1; a_cpu_addr = 16'h0010; a_cpu_wd = 32'h1234_5678;
    step(); #1;
    total++; if (a_r_stb !== 1'b1 || a_r_we !== 1'b1) begin
      bad++; $display("FAIL cpuw_stb got stb=%0h we=%0h exp=1/1", a_r_stb, a_r_we);
    end
    total++; if (a_r_addr !== 16'h0010 || a_r_wd !== 32'h1234_5678) begin
      bad++; $display("FAIL cpuw_fields got addr=%0h data=%0h exp=10/12345678", a_r_addr, a_r_wd);
    end
    total++; if (a_owner !== 2'b01) begin bad++; $display("FAIL cpuw_owner got=%0h exp=1", a_owner); end
    step();
    step(); a_r_ack = 1; a_r_rd = 32'h5555_AAAA; #1;
    total++; if (a_cpu_ack !== 1'b1 || a_cpu_err !== 1'b0 || a_dma_ack !== 1'b0) begin
      bad++; $display("FAIL cpuw_ack got ack=%0h err=%0h dma=%0h exp=1/0/0", a_cpu_ack, a_cpu_err, a_dma_ack);
    end
    step(); a_r_ack = 0; a_cpu_stb = 0; #1;
    total++; if (a_r_stb !== 1'b0 || a_owner !== 2'b00 || a_cpu_ack !== 1'b0) begin
      bad++; $display("FAIL cpuw_after got stb=%0h owner=%0h ack=%0h exp=0/0/0", a_r_stb, a_owner, a_cpu_ack);
    end
    step();
  endtask

  task automatic test_dma_read();
    a_dma_stb = 1; a_dma_we = 0; a_dma_addr = 16'h0200; a_dma_wd = 32'h0;
    step(); #1;
    total++; if (a_r_stb !== 1'b1 || a_owner !== 2'b10 || a_r_we !== 1'b0 || a_r_addr !== 16'h0200) begin
      bad++; $display("FAIL dmar_grant got stb=%0h owner=%0h we=%0h addr=%0h exp=1/2/0/200",
                      a_r_stb, a_owner, a_r_we, a_r_addr);
    end
    step(); a_r_ack = 1; a_r_rd = 32'hCAFE_F00D; #1;
    total++; if (a_dma_ack !== 1'b1 || a_dma_rd !== 32'hCAFE_F00D || a_dma_err !== 1'b0) begin
      bad++; $display("FAIL dmar_ack got ack=%0h data=%0h err=%0h exp=1/cafef00d/0", a_dma_ack, a_dma_rd, a_dma_err);
    end
    total++; if (a_cpu_ack !== 1'b0 || a_cpu_rd !== '0) begin
      bad++; $display("FAIL dmar_nonowner got ack=%0h data=%0h exp=0/0", a_cpu_ack, a_cpu_rd);
    end
    step(); a_r_ack = 0; a_dma_stb = 0;
    step();
  endtask

  task automatic test_ack_in_idle();
    step(); a_r_ack = 1; a_r_rd = 32'h1111_2222; #1;
    total++; if (a_cpu_ack !== 1'b0 || a_dma_ack !== 1'b0 || a_owner !== 2'b00) begin
      bad++; $display("FAIL idle_ack got cpu=%0h dma=%0h owner=%0h exp=0/0/0", a_cpu_ack, a_dma_ack, a_owner);
    end
    step(); a_r_ack = 0;
  endtask

  task automatic test_back_to_back();
    int ack_cyc;
    logic seen;
    logic [1:0] exp_own;
    apply_reset();
    a_cpu_stb = 1; a_cpu_we = 1; a_cpu_addr = 16'h0100; a_cpu_wd = 32'hC0C0_0001;
    a_dma_stb = 1; a_dma_we = 0; a_dma_addr = 16'h0300; a_dma_wd = 32'hD0D0_0002;
    ack_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        step(); a_r_ack = 0; #1;
        if (a_r_stb === 1'b1) seen = 1;
      end
      total++; if (!seen) begin bad++; $display("FAIL b2b_timeout grant=%0d got=no_stb exp=stb", g); break; end
      exp_own = (g % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (a_owner !== exp_own) begin bad++; $display("FAIL b2b_owner grant=%0d got=%0h exp=%0h", g, a_owner, exp_own); end
      if (g > 0) begin
        total++; if (cyc - ack_cyc !== 2) begin bad++; $display("FAIL b2b_gap grant=%0d got=%0d exp=2", g, cyc - ack_cyc); end
      end
      step(); a_r_ack = 1; a_r_rd = 32'h0 + g; #1;
      ack_cyc = cyc;
      total++; if ({a_dma_ack, a_cpu_ack} !== exp_own) begin
        bad++; $display("FAIL b2b_ack grant=%0d got=%0h exp=%0h", g, {a_dma_ack, a_cpu_ack}, exp_own);
      end
    end
    step(); a_r_ack = 0; a_cpu_stb = 0; a_dma_stb = 0;
    step(); step();
  endtask

  task automatic test_timeout();
    a_cpu_stb = 1; a_cpu_we = 0; a_cpu_addr = 16'h0444; a_cpu_wd = 0;
    for (int i = 1; i <= TO; i++) begin
      step(); #1;
      if (i < TO) begin
        total++; if (a_cpu_ack !== 1'b0) begin bad++; $display("FAIL to_early cycle=%0d got=%0h exp=0", i, a_cpu_ack); end
      end else begin
        total++; if (a_cpu_ack !== 1'b1 || a_cpu_err !== 1'b1 || a_cpu_rd !== ERR) begin
          bad++; $display("FAIL to_ack got ack=%0h err=%0h data=%0h exp=1/1/%0h", a_cpu_ack, a_cpu_err, a_cpu_rd, ERR);
        end
        total++; if (a_dma_ack !== 1'b0 || a_dma_err !== 1'b0) begin
          bad++; $display("FAIL to_nonowner got ack=%0h err=%0h exp=0/0", a_dma_ack, a_dma_err);
        end
      end
    end
    step(); a_cpu_stb = 0; #1;
    total++; if (a_r_stb !== 1'b0 || a_owner !== 2'b00) begin
      bad++; $display("FAIL to_release got stb=%0h owner=%0h exp=0/0", a_r_stb, a_owner);
    end
    step();
  endtask

  task automatic test_ack_vs_timeout();
    a_cpu_stb = 1; a_cpu_we = 0; a_cpu_addr = 16'h0888;
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i == TO) begin a_r_ack = 1; a_r_rd = 32'h0BAD_F00D; end
    end
    #1;
    total++; if (a_cpu_ack !== 1'b1 || a_cpu_err !== 1'b0 || a_cpu_rd !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL ack_vs_to got ack=%0h err=%0h data=%0h exp=1/0/badf00d", a_cpu_ack, a_cpu_err, a_cpu_rd);
    end
    step(); a_r_ack = 0; a_cpu_stb = 0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    a_dma_stb = 1; a_dma_we = 1; a_dma_addr = 16'h0123; a_dma_wd = 32'h7777_0000;
    step(); step(); #1;
    total++; if (a_r_stb !== 1'b1 || a_owner !== 2'b10) begin
      bad++; $display("FAIL rstbusy_pre got stb=%0h owner=%0h exp=1/2", a_r_stb, a_owner);
    end
    step(); rst_n = 0; a_dma_stb = 0; #1;
    total++; if (a_r_stb !== 1'b0 || a_owner !== 2'b00) begin
      bad++; $display("FAIL rstbusy_async got stb=%0h owner=%0h exp=0/0", a_r_stb, a_owner);
    end
    step(); rst_n = 1;
    step(); a_r_ack = 1; a_r_rd = 32'h9999_9999; #1;
    total++; if (a_dma_ack !== 1'b0 || a_owner !== 2'b00) begin
      bad++; $display("FAIL rstbusy_ack got ack=%0h owner=%0h exp=0/0", a_dma_ack, a_owner);
    end
    step(); a_r_ack = 0;
  endtask

  task automatic test_priority();
    logic seen;
    logic dma_seen;
    apply_reset();
    b_cpu_stb = 1; b_cpu_we = 1; b_cpu_addr = 16'h0ABC; b_cpu_wd = 32'h1;
    b_dma_stb = 1; b_dma_we = 1; b_dma_addr = 16'h0DEF; b_dma_wd = 32'h2;
    dma_seen = 0;
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        step(); b_r_ack = 0; #1;
        if (b_dma_ack === 1'b1) dma_seen = 1;
        if (b_r_stb === 1'b1) seen = 1;
      end
      total++; if (!seen) begin bad++; $display("FAIL prio_timeout grant=%0d got=no_stb exp=stb", g); break; end
      total++; if (b_owner !== 2'b01 || b_r_addr !== 16'h0ABC) begin
        bad++; $display("FAIL prio_owner grant=%0d got owner=%0h addr=%0h exp=1/abc", g, b_owner, b_r_addr);
      end
      step(); b_r_ack = 1; #1;
      if (b_dma_ack === 1'b1) dma_seen = 1;
      total++; if (b_cpu_ack !== 1'b1) begin bad++; $display("FAIL prio_ack grant=%0d got=%0h exp=1", g, b_cpu_ack); end
    end
    total++; if (dma_seen !== 1'b0) begin bad++; $display("FAIL prio_dma_ack got=%0h exp=0", dma_seen); end
    step(); b_r_ack = 0; b_cpu_stb = 0; b_dma_stb = 0;
    step();
  endtask

  // Randomized traffic on u_a against a transaction-level model: one access at
  // a time, a one-cycle idle gap after each completion, round-robin on ties,
  // and completion at the slave's chosen cycle or at cycle TO, whichever is first.
  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic [1:0] pend;
    logic m_busy, exp_grant, idle_now, done;
    int m_own, m_cnt, k, last_own, win, n_done, fin;
    logic [DW-1:0] rdata, exp_d;
    logic [1:0] exp_ack;
    apply_reset();
    pend = 0; m_busy = 0; exp_grant = 0; last_own = 2; n_done = 0;
    m_own = 0; m_cnt = 0; k = 1; win = 0; rdata = 0;
    for (int c = 0; c < 3000 && n_done < 80; c++) begin
      step();
      if (exp_grant) begin
        exp_grant = 0; m_busy = 1; m_own = win; m_cnt = 0;
        k = $urandom_range(1, 10);
        rdata = $urandom;
        exp_q.push_back((k <= TO) ? rdata : ERR);
        total++;
        if (win == 1 && (a_r_we !== a_cpu_we || a_r_addr !== a_cpu_addr || a_r_wd !== a_cpu_wd)) begin
          bad++; $display("FAIL rnd_cpu_fields got we=%0h addr=%0h data=%0h exp=%0h/%0h/%0h",
                          a_r_we, a_r_addr, a_r_wd, a_cpu_we, a_cpu_addr, a_cpu_wd);
        end else if (win == 2 && (a_r_we !== a_dma_we || a_r_addr !== a_dma_addr || a_r_wd !== a_dma_wd)) begin
          bad++; $display("FAIL rnd_dma_fields got we=%0h addr=%0h data=%0h exp=%0h/%0h/%0h",
                          a_r_we, a_r_addr, a_r_wd, a_dma_we, a_dma_addr, a_dma_wd);
        end
      end
      total++; if (a_r_stb !== m_busy || a_owner !== (m_busy ? 2'(m_own) : 2'b00)) begin
        bad++; $display("FAIL rnd_state cyc=%0d got stb=%0h owner=%0h exp=%0h/%0h", c, a_r_stb, a_owner,
                        m_busy, m_busy ? m_own : 0);
      end
      idle_now = !m_busy;
      if (!pend[0]) begin
        if ($urandom_range(0, 1) == 1) begin
          pend[0] = 1; a_cpu_stb = 1; a_cpu_we = 1'($urandom_range(0, 1));
          a_cpu_addr = 16'($urandom); a_cpu_wd = $urandom;
        end else a_cpu_stb = 0;
      end
      if (!pend[1]) begin
        if ($urandom_range(0, 2) == 0) begin
          pend[1] = 1; a_dma_stb = 1; a_dma_we = 1'($urandom_range(0, 1));
          a_dma_addr = 16'($urandom); a_dma_wd = $urandom;
        end else a_dma_stb = 0;
      end
      a_r_ack = 0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == k && k <= TO) begin a_r_ack = 1; a_r_rd = rdata; end
      end
      #1;
      fin = (k < TO) ? k : TO;
      done = m_busy && (m_cnt == fin);
      exp_ack = done ? 2'(m_own) : 2'b00;
      total++; if ({a_dma_ack, a_cpu_ack} !== exp_ack) begin
        bad++; $display("FAIL rnd_ack cyc=%0d got=%0h exp=%0h", c, {a_dma_ack, a_cpu_ack}, exp_ack);
      end
      if (done) begin
        exp_d = exp_q.pop_front();
        total++;
        if (m_own == 1 && (a_cpu_rd !== exp_d || a_cpu_err !== (k > TO) || a_dma_rd !== '0)) begin
          bad++; $display("FAIL rnd_cpu_resp got data=%0h err=%0h other=%0h exp=%0h/%0h/0",
                          a_cpu_rd, a_cpu_err, a_dma_rd, exp_d, k > TO);
        end else if (m_own == 2 && (a_dma_rd !== exp_d || a_dma_err !== (k > TO) || a_cpu_rd !== '0)) begin
          bad++; $display("FAIL rnd_dma_resp got data=%0h err=%0h other=%0h exp=%0h/%0h/0",
                          a_dma_rd, a_dma_err, a_cpu_rd, exp_d, k > TO);
        end
        pend[m_own-1] = 0;
        last_own = m_own;
        m_busy = 0;
        n_done++;
      end
      if (idle_now && (a_cpu_stb || a_dma_stb)) begin
        exp_grant = 1;
        if (a_cpu_stb && a_dma_stb) win = (last_own == 1) ? 2 : 1;
        else win = a_cpu_stb ? 1 : 2;
      end
    end
    total++; if (n_done < 80) begin bad++; $display("FAIL rnd_progress got=%0d exp=80", n_done); end
    apply_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_all();
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_ack_in_idle();
    test_back_to_back();
    test_timeout();
    test_ack_vs_timeout();
    test_reset_mid_busy();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
